// File: rtl/alloc_req_arbiter_if.sv
// rtl/alloc_req_arbiter_if.sv - client and allocator-core signal bundle for alloc_req_arbiter
//
// Purpose: groups the per-port client request/response signals and the
// single-channel allocator core handshake into one interface.
// Modports:
//   slave  - arbiter view (requests and core responses in; done/core strobes out)
//   master - client/core view (the opposite directions)
// Signals:
//   alloc_i/free_i/force_free_i/set_usecnt_i [g_num_ports]  per-port request strobes
//   pg_addr_i  [g_num_ports*g_page_addr_width]  per-port page address
//   usecnt_i   [g_num_ports*g_usecnt_width]     per-port use count
//   done_o     [g_num_ports]  one-cycle completion pulse per port
//   pg_addr_alloc_o           page returned by the last completed alloc
//   core_*_o                  operation strobes and operands to the core
//   core_done_i, core_pg_addr_alloc_i, core_nomem_i  core responses
interface alloc_req_arbiter_if #(
    parameter int g_num_ports       = 4,
    parameter int g_page_addr_width = 10,
    parameter int g_usecnt_width    = 5
);
    logic [g_num_ports-1:0]                   alloc_i;
    logic [g_num_ports-1:0]                   free_i;
    logic [g_num_ports-1:0]                   force_free_i;
    logic [g_num_ports-1:0]                   set_usecnt_i;
    logic [g_num_ports*g_page_addr_width-1:0] pg_addr_i;
    logic [g_num_ports*g_usecnt_width-1:0]    usecnt_i;
    logic [g_num_ports-1:0]                   done_o;
    logic [g_page_addr_width-1:0]             pg_addr_alloc_o;

    logic                                     core_alloc_o;
    logic                                     core_free_o;
    logic                                     core_force_free_o;
    logic                                     core_set_usecnt_o;
    logic [g_page_addr_width-1:0]             core_pg_addr_o;
    logic [g_usecnt_width-1:0]                core_usecnt_o;
    logic                                     core_done_i;
    logic [g_page_addr_width-1:0]             core_pg_addr_alloc_i;
    logic                                     core_nomem_i;

    modport slave (
        input  alloc_i, free_i, force_free_i, set_usecnt_i, pg_addr_i, usecnt_i,
        output done_o, pg_addr_alloc_o,
        output core_alloc_o, core_free_o, core_force_free_o, core_set_usecnt_o,
        output core_pg_addr_o, core_usecnt_o,
        input  core_done_i, core_pg_addr_alloc_i, core_nomem_i
    );

    modport master (
        output alloc_i, free_i, force_free_i, set_usecnt_i, pg_addr_i, usecnt_i,
        input  done_o, pg_addr_alloc_o,
        input  core_alloc_o, core_free_o, core_force_free_o, core_set_usecnt_o,
        input  core_pg_addr_o, core_usecnt_o,
        output core_done_i, core_pg_addr_alloc_i, core_nomem_i
    );
endinterface

// File: rtl/alloc_req_arbiter.sv
// rtl/alloc_req_arbiter.sv - round-robin arbiter of client page-allocator requests onto one core
//
// Purpose: grants one client port at a time to the page allocator core.
// Per port, the operation is chosen force_free > free > set_usecnt > alloc;
// ports are served round-robin starting after the last completed port.
// Ports:
//   clk_i     clock, rising edge
//   rst_n_i   asynchronous active-low reset
//   bus       alloc_req_arbiter_if.slave (client requests/done, core handshake)
//   op_cnt_o  16-bit completed-operation counter, present only when the
//             macro ALLOC_ARB_OP_CNT_EN is defined
module alloc_req_arbiter #(
    parameter int g_num_ports       = 4,
    parameter int g_page_addr_width = 10,
    parameter int g_usecnt_width    = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    alloc_req_arbiter_if.slave   bus
`ifdef ALLOC_ARB_OP_CNT_EN
    ,
    output logic [15:0]          op_cnt_o
`endif
);
    localparam int c_pw = (g_num_ports > 1) ? $clog2(g_num_ports) : 1;
    localparam int c_aw = g_page_addr_width;
    localparam int c_uw = g_usecnt_width;

    typedef enum logic [1:0] {OP_ALLOC, OP_FREE, OP_FORCE_FREE, OP_SET_USECNT} op_t;
    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t                 state_q, state_d;
    op_t                    op_q;
    logic [c_pw-1:0]        port_q;
    logic [c_pw-1:0]        rr_ptr_q;
    logic [c_aw-1:0]        addr_q;
    logic [c_uw-1:0]        usecnt_q;
    logic [g_num_ports-1:0] done_q;
    logic [c_aw-1:0]        pg_alloc_q;

    op_t                    port_op [g_num_ports];
    logic [g_num_ports-1:0] port_elig;
    logic                   grant_found;
    logic [c_pw-1:0]        grant_port;
    logic [c_pw-1:0]        cand;
    logic                   core_alloc, core_free, core_force_free, core_set_usecnt;

    // Per-port operation selection and eligibility. done_q doubles as the
    // one-cycle mask: a port whose done pulse is showing cannot be regranted
    // before its client has had a chance to drop the request.
    always_comb begin
        for (int p = 0; p < g_num_ports; p++) begin
            if (bus.force_free_i[p])
                port_op[p] = OP_FORCE_FREE;
            else if (bus.free_i[p])
                port_op[p] = OP_FREE;
            else if (bus.set_usecnt_i[p])
                port_op[p] = OP_SET_USECNT;
            else
                port_op[p] = OP_ALLOC;
            port_elig[p] = (bus.alloc_i[p] | bus.free_i[p] | bus.force_free_i[p] |
                            bus.set_usecnt_i[p]) && !done_q[p] &&
                           !(port_op[p] == OP_ALLOC && bus.core_nomem_i);
        end
    end

    // First eligible port at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_port  = '0;
        cand        = '0;
        for (int i = 0; i < g_num_ports; i++) begin
            cand = c_pw'((int'(rr_ptr_q) + i) % g_num_ports);
            if (!grant_found && port_elig[cand]) begin
                grant_found = 1'b1;
                grant_port  = cand;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        core_alloc      = 1'b0;
        core_free       = 1'b0;
        core_force_free = 1'b0;
        core_set_usecnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_found)
                    state_d = ST_BUSY;
            end
            ST_BUSY: begin
                core_alloc      = (op_q == OP_ALLOC);
                core_free       = (op_q == OP_FREE);
                core_force_free = (op_q == OP_FORCE_FREE);
                core_set_usecnt = (op_q == OP_SET_USECNT);
                if (bus.core_done_i)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            op_q       <= OP_ALLOC;
            port_q     <= '0;
            rr_ptr_q   <= '0;
            addr_q     <= '0;
            usecnt_q   <= '0;
            done_q     <= '0;
            pg_alloc_q <= '0;
        end else begin
            done_q <= '0;
            if (state_q == ST_IDLE && grant_found) begin
                port_q   <= grant_port;
                op_q     <= port_op[grant_port];
                addr_q   <= bus.pg_addr_i[grant_port*c_aw +: c_aw];
                usecnt_q <= bus.usecnt_i[grant_port*c_uw +: c_uw];
            end
            if (state_q == ST_BUSY && bus.core_done_i) begin
                done_q[port_q] <= 1'b1;
                rr_ptr_q       <= (port_q == c_pw'(g_num_ports - 1)) ? '0 : port_q + 1'b1;
                if (op_q == OP_ALLOC)
                    pg_alloc_q <= bus.core_pg_addr_alloc_i;
            end
        end
    end

`ifdef ALLOC_ARB_OP_CNT_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            op_cnt_q <= '0;
        else if (|done_q)
            op_cnt_q <= op_cnt_q + 16'd1;
    end

    assign op_cnt_o = op_cnt_q;
`endif

    assign bus.done_o            = done_q;
    assign bus.pg_addr_alloc_o   = pg_alloc_q;
    assign bus.core_alloc_o      = core_alloc;
    assign bus.core_free_o       = core_free;
    assign bus.core_force_free_o = core_force_free;
    assign bus.core_set_usecnt_o = core_set_usecnt;
    assign bus.core_pg_addr_o    = addr_q;
    assign bus.core_usecnt_o     = usecnt_q;
endmodule

// File: tb/tb_alloc_req_arbiter.sv
// tb/tb_alloc_req_arbiter.sv - directed self-checking bench for alloc_req_arbiter
module tb_alloc_req_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    alloc_req_arbiter_if #(.g_num_ports(4), .g_page_addr_width(10), .g_usecnt_width(5)) bus();

`ifdef ALLOC_ARB_OP_CNT_EN
    logic [15:0] op_cnt;
`endif

    alloc_req_arbiter #(.g_num_ports(4), .g_page_addr_width(10), .g_usecnt_width(5)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
`ifdef ALLOC_ARB_OP_CNT_EN
        ,
        .op_cnt_o(op_cnt)
`endif
    );

    always #5 clk = ~clk;

    // {force_free, free, set_usecnt, alloc}
    logic [3:0] strb;
    assign strb = {bus.core_force_free_o, bus.core_free_o, bus.core_set_usecnt_o, bus.core_alloc_o};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [9:0] a);
        bus.pg_addr_i[p*10 +: 10] = a;
    endtask

    task automatic set_ucnt(input int p, input logic [4:0] u);
        bus.usecnt_i[p*5 +: 5] = u;
    endtask

    initial begin
        bus.alloc_i              = '0;
        bus.free_i               = '0;
        bus.force_free_i         = '0;
        bus.set_usecnt_i         = '0;
        bus.pg_addr_i            = '0;
        bus.usecnt_i             = '0;
        bus.core_done_i          = 1'b0;
        bus.core_pg_addr_alloc_i = '0;
        bus.core_nomem_i         = 1'b0;

        tick();
        tick();
        chk_eq("rst_strb", 32'(strb), 32'h0);
        chk_eq("rst_done", 32'(bus.done_o), 32'h0);
        chk_eq("rst_addr", 32'(bus.core_pg_addr_o), 32'h0);
        chk_eq("rst_ucnt", 32'(bus.core_usecnt_o), 32'h0);
        chk_eq("rst_pgal", 32'(bus.pg_addr_alloc_o), 32'h0);
        rst_n = 1'b1;

        // all four ports free at once, core answers immediately
        for (int p = 0; p < 4; p++) set_addr(p, 10'(16 + p));
        bus.free_i      = 4'b1111;
        bus.core_done_i = 1'b1;
        for (int p = 0; p < 4; p++) begin
            tick();
            chk_eq($sformatf("rr_strb%0d", p), 32'(strb), 32'h4);
            chk_eq($sformatf("rr_addr%0d", p), 32'(bus.core_pg_addr_o), 32'(16 + p));
            chk_eq($sformatf("rr_nodone%0d", p), 32'(bus.done_o), 32'h0);
            tick();
            chk_eq($sformatf("rr_done%0d", p), 32'(bus.done_o), 32'(1 << p));
            bus.free_i[p] = 1'b0;
        end
        bus.core_done_i = 1'b0;
        tick();
        chk_eq("rr_end_strb", 32'(strb), 32'h0);
        chk_eq("rr_end_done", 32'(bus.done_o), 32'h0);

        // single alloc on port 0, page 0x05
        set_ucnt(0, 5'd2);
        bus.alloc_i[0] = 1'b1;
        tick();
        chk_eq("al_strb", 32'(strb), 32'h1);
        chk_eq("al_ucnt", 32'(bus.core_usecnt_o), 32'd2);
        bus.core_done_i          = 1'b1;
        bus.core_pg_addr_alloc_i = 10'h005;
        tick();
        chk_eq("al_strb_off", 32'(strb), 32'h0);
        chk_eq("al_done", 32'(bus.done_o), 32'h1);
        chk_eq("al_page", 32'(bus.pg_addr_alloc_o), 32'h005);
        bus.alloc_i[0]  = 1'b0;
        bus.core_done_i = 1'b0;
        tick();
        chk_eq("al_done_off", 32'(bus.done_o), 32'h0);

        // port 1 keeps its request through the done cycle: masked, not regranted
        set_addr(1, 10'h021);
        bus.free_i[1]   = 1'b1;
        bus.core_done_i = 1'b1;
        tick();
        chk_eq("mk_strb", 32'(strb), 32'h4);
        tick();
        chk_eq("mk_done", 32'(bus.done_o), 32'h2);
        tick();
        chk_eq("mk_masked", 32'(strb), 32'h0);
        bus.free_i[1]   = 1'b0;
        bus.core_done_i = 1'b0;
        tick();

        // nomem: port 1 alloc blocked, port 2 free served
        bus.core_nomem_i = 1'b1;
        set_ucnt(1, 5'd3);
        set_addr(2, 10'h032);
        bus.alloc_i[1] = 1'b1;
        bus.free_i[2]  = 1'b1;
        tick();
        chk_eq("nm_strb", 32'(strb), 32'h4);
        chk_eq("nm_addr", 32'(bus.core_pg_addr_o), 32'h032);
        bus.core_done_i = 1'b1;
        tick();
        chk_eq("nm_done", 32'(bus.done_o), 32'h4);
        bus.free_i[2]   = 1'b0;
        bus.core_done_i = 1'b0;
        tick();
        chk_eq("nm_blocked", 32'(strb), 32'h0);
        bus.core_nomem_i = 1'b0;
        tick();
        chk_eq("nm_al_strb", 32'(strb), 32'h1);
        chk_eq("nm_al_ucnt", 32'(bus.core_usecnt_o), 32'd3);
        bus.core_nomem_i         = 1'b1;
        bus.core_done_i          = 1'b1;
        bus.core_pg_addr_alloc_i = 10'h02A;
        tick();
        chk_eq("nm_al_done", 32'(bus.done_o), 32'h2);
        chk_eq("nm_al_page", 32'(bus.pg_addr_alloc_o), 32'h02A);
        bus.alloc_i[1]   = 1'b0;
        bus.core_nomem_i = 1'b0;
        bus.core_done_i  = 1'b0;
        tick();

        // port 3 force_free wins over free and alloc
        set_addr(3, 10'h3FF);
        bus.free_i[3]       = 1'b1;
        bus.force_free_i[3] = 1'b1;
        bus.alloc_i[3]      = 1'b1;
        tick();
        chk_eq("ff_strb", 32'(strb), 32'h8);
        chk_eq("ff_addr", 32'(bus.core_pg_addr_o), 32'h3FF);
        bus.core_done_i = 1'b1;
        tick();
        chk_eq("ff_done", 32'(bus.done_o), 32'h8);
        bus.free_i[3]       = 1'b0;
        bus.force_free_i[3] = 1'b0;
        bus.alloc_i[3]      = 1'b0;
        bus.core_done_i     = 1'b0;

        // port 0 set_usecnt wins over alloc; pg_addr_alloc_o untouched
        set_addr(0, 10'h055);
        set_ucnt(0, 5'd7);
        bus.set_usecnt_i[0] = 1'b1;
        bus.alloc_i[0]      = 1'b1;
        bus.core_pg_addr_alloc_i = 10'h111;
        tick();
        chk_eq("su_strb", 32'(strb), 32'h2);
        chk_eq("su_ucnt", 32'(bus.core_usecnt_o), 32'd7);
        chk_eq("su_addr", 32'(bus.core_pg_addr_o), 32'h055);
        bus.core_done_i = 1'b1;
        tick();
        chk_eq("su_done", 32'(bus.done_o), 32'h1);
        chk_eq("su_page", 32'(bus.pg_addr_alloc_o), 32'h02A);
        bus.set_usecnt_i[0] = 1'b0;
        bus.alloc_i[0]      = 1'b0;
        bus.core_done_i     = 1'b0;

        // reset in BUSY with core_done withheld
        bus.free_i[2] = 1'b1;
        tick();
        chk_eq("rb_busy", 32'(strb), 32'h4);
        rst_n = 1'b0;
        #1;
        chk_eq("rb_strb", 32'(strb), 32'h0);
        chk_eq("rb_addr", 32'(bus.core_pg_addr_o), 32'h0);
        chk_eq("rb_pgal", 32'(bus.pg_addr_alloc_o), 32'h0);
        bus.free_i[2] = 1'b0;
        tick();
        tick();
        chk_eq("rb_nodone", 32'(bus.done_o), 32'h0);
        rst_n = 1'b1;
        bus.free_i = 4'b1001;
        tick();
        chk_eq("rb_port0_strb", 32'(strb), 32'h4);
        chk_eq("rb_port0_addr", 32'(bus.core_pg_addr_o), 32'h055);
        bus.core_done_i = 1'b1;
        tick();
        chk_eq("rb_port0_done", 32'(bus.done_o), 32'h1);
        bus.free_i      = 4'b0000;
        bus.core_done_i = 1'b0;
        tick();
`ifdef ALLOC_ARB_OP_CNT_EN
        chk_eq("op_cnt", 32'(op_cnt), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alloc_req_arbiter.md
ALLOC_REQ_ARBITER -- requirements
Module: alloc_req_arbiter

Interface
REQ-001 Parameter g_num_ports, default 4, SHALL set the number of client ports (2..16).
REQ-002 Parameter g_page_addr_width, default 10, SHALL set the page address width.
REQ-003 Parameter g_usecnt_width, default 5, SHALL set the use-count width.
REQ-004 clk_i  in  1  SHALL be the single clock; all state is updated on its rising edge.
REQ-005 rst_n_i  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 alloc_i / free_i / force_free_i / set_usecnt_i  in  g_num_ports each  SHALL be the per-port request strobes, bit p for port p.
REQ-007 pg_addr_i  in  g_num_ports*g_page_addr_width  SHALL be the per-port page address for free, force_free and set_usecnt; port p occupies slice p.
REQ-008 usecnt_i  in  g_num_ports*g_usecnt_width  SHALL be the per-port use count for alloc and set_usecnt.
REQ-009 done_o  out  g_num_ports  SHALL be a one-cycle completion pulse per port.
REQ-010 pg_addr_alloc_o  out  g_page_addr_width  SHALL be the page returned by the last completed alloc; it is valid while that port's done_o is high.
REQ-011 core_alloc_o / core_free_o / core_force_free_o / core_set_usecnt_o  out  1 each  SHALL be the strobes to the allocator core.
REQ-012 core_pg_addr_o (g_page_addr_width) and core_usecnt_o (g_usecnt_width)  out  SHALL carry the granted port's operands.
REQ-013 core_done_i  in  1  SHALL be the allocator core completion indication.
REQ-014 core_pg_addr_alloc_i  in  g_page_addr_width  SHALL be the page allocated by the core.
REQ-015 core_nomem_i  in  1  SHALL be asserted by the core when no free page exists.

Function
REQ-016 The block SHALL be an FSM with states IDLE and BUSY.
REQ-017 Port p SHALL be eligible in IDLE if any of its request bits is set, it is not masked (REQ-023), and its request is not an alloc while core_nomem_i=1.
REQ-018 Within one port, the operation SHALL be chosen by priority force_free > free > set_usecnt > alloc; lower-priority bits are ignored for that grant.
REQ-019 In IDLE, the first eligible port at or after rr_ptr (wrapping modulo g_num_ports) SHALL be granted; its port index, operation, address and use count are registered and the FSM enters BUSY.
REQ-020 In BUSY, exactly one core strobe SHALL be high, with core_pg_addr_o and core_usecnt_o stable, until the cycle core_done_i=1 is sampled.
REQ-021 On sampling core_done_i=1, the block SHALL on the next edge drop the core strobe, pulse done_o[p] for one cycle, register core_pg_addr_alloc_i into pg_addr_alloc_o (alloc only), set rr_ptr=(p+1) mod g_num_ports, and return to IDLE.
REQ-022 Minimum request-to-done_o latency SHALL be 3 cycles (grant, core strobe with core_done_i=1, done_o); only one operation is outstanding at any time.
REQ-023 During the IDLE cycle immediately following done_o[p], port p SHALL be masked from arbitration, so a client that drops its request on seeing done_o is not granted twice.
REQ-024 Clients SHALL hold their request and operands stable until done_o; request changes of a granted port during BUSY SHALL have no effect.
REQ-025 A port blocked only by core_nomem_i SHALL NOT stall other ports; a free or force_free request from any port SHALL be granted.
REQ-026 If core_nomem_i rises while an alloc is in BUSY, the operation SHALL be completed normally on core_done_i.

Reset
REQ-027 Asserting rst_n_i low SHALL immediately set state=IDLE, rr_ptr=0, mask cleared, all core strobes=0, done_o=0, core_pg_addr_o=0, core_usecnt_o=0, pg_addr_alloc_o=0.
REQ-028 Reset asserted mid-BUSY SHALL abandon the operation without a done_o pulse; arbitration SHALL resume on the first edge after release.

Configuration
REQ-029 With macro ALLOC_ARB_OP_CNT_EN defined, the block SHALL expose output op_cnt_o (16 bits), incremented on each done_o pulse, wrapping 0xFFFF->0, reset to 0.
REQ-030 Without ALLOC_ARB_OP_CNT_EN, op_cnt_o and its counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-031 Single port 0 alloc, usecnt=2, core returns page 0x05 with core_done_i one cycle after strobe -> core_alloc_o high 1 cycle, done_o[0] pulses, pg_addr_alloc_o=0x05.
REQ-032 Ports 0..3 all request free simultaneously, core_done_i immediate -> grants in order 0,1,2,3, each done_o pulse single-cycle, no port granted twice.
REQ-033 core_nomem_i=1, port 1 alloc and port 2 free pending -> port 2 granted; after core_nomem_i=0, port 1 alloc granted.
REQ-034 Port 3 asserts free and force_free together, pg_addr=0x3FF -> only core_force_free_o asserted, core_pg_addr_o=0x3FF.
REQ-035 Reset asserted in BUSY with core_done_i withheld -> all strobes low immediately, no done_o; new request after release granted from port 0.
REQ-036 With ALLOC_ARB_OP_CNT_EN, 65537 completed operations -> op_cnt_o=1.
